// File: rtl/clear_datapath.sv
// ============================================================================
// clear_datapath : x/y scan counters, plot counter and frame flag for a
//                  VGA screen-clear controller. Option macro: CLEAR_BLACK_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module clear_datapath #(
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        initx,
  input  logic        inity,
  input  logic        loadx,
  input  logic        loady,
  input  logic        plot,
  output logic        xdone,
  output logic        ydone,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [14:0] pix_count,
  output logic        frame_done
);

  localparam logic [7:0]  c_xlast  = 8'(XMAX - 1);
  localparam logic [6:0]  c_ylast  = 7'(YMAX - 1);
  localparam logic [14:0] c_pixmax = 15'h7fff;

  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [14:0] r_pix_count;
  logic        r_frame_done;
  logic        w_start;

  // Controller start: both counters re-initialised in the same cycle.
  assign w_start = loadx & initx & loady & inity;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x          <= 8'd0;
      r_y          <= 7'd0;
      r_pix_count  <= 15'd0;
      r_frame_done <= 1'b0;
    end else begin
      if (loadx) begin
        if (initx || (r_x == c_xlast)) r_x <= 8'd0;
        else                           r_x <= r_x + 8'd1;
      end
      if (loady) begin
        if (inity || (r_y == c_ylast)) r_y <= 7'd0;
        else                           r_y <= r_y + 7'd1;
      end
      if (w_start)                            r_pix_count <= 15'd0;
      else if (plot && (r_pix_count != c_pixmax)) r_pix_count <= r_pix_count + 15'd1;
      if (w_start)            r_frame_done <= 1'b0;
      else if (plot && xdone) r_frame_done <= 1'b1;
    end
  end

  assign ydone      = (r_y == c_ylast);
  assign xdone      = (r_x == c_xlast) && ydone;
  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_plot   = plot;
  assign pix_count  = r_pix_count;
  assign frame_done = r_frame_done;

`ifdef CLEAR_BLACK_EN
  assign vga_colour = 3'b000;
`else
  assign vga_colour = r_x[2:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_clear_datapath.sv
// ============================================================================
// tb_clear_datapath : directed self-checking bench for clear_datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clear_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        initx, inity, loadx, loady, plot;
  logic        xdone, ydone, vga_plot, frame_done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic [14:0] pix_count;

  int n_checks = 0;
  int n_errors = 0;

  clear_datapath #(.XMAX(160), .YMAX(120)) dut (
    .clock(clock), .reset(reset), .initx(initx), .inity(inity),
    .loadx(loadx), .loady(loady), .plot(plot), .xdone(xdone), .ydone(ydone),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .pix_count(pix_count), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic lx, input logic ix, input logic ly, input logic iy, input logic p);
    loadx = lx; initx = ix; loady = ly; inity = iy; plot = p;
  endtask

  logic [2:0] exp_col13;
  int         nplots;
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic       done;

  initial begin
`ifdef CLEAR_BLACK_EN
    exp_col13 = 3'b000;
`else
    exp_col13 = 3'b101;
`endif
    reset = 1'b1;
    drive(1, 1, 1, 1, 1);
    step();
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_pix", pix_count, 0);
    check("rst_fd", frame_done, 0);
    check("rst_xdone", xdone, 0);
    check("rst_ydone", ydone, 0);
    check("rst_colour", vga_colour, 0);
    reset = 1'b0;

    // Walk x to 13, then to 159; y to 118 then 119.
    drive(1, 0, 0, 0, 0);
    repeat (13) step();
    check("x13", vga_x, 13);
    check("colour_x13", vga_colour, exp_col13);
    repeat (146) step();
    check("x159", vga_x, 159);
    drive(0, 1, 0, 1, 0);
    step();
    check("initx_ignored", vga_x, 159);
    drive(0, 0, 1, 0, 0);
    repeat (118) step();
    check("y118", vga_y, 118);
    check("xdone_y118", xdone, 0);
    check("ydone_y118", ydone, 0);
    step();
    check("ydone_y119", ydone, 1);
    check("xdone_y119", xdone, 1);
    check("pix_noplot", pix_count, 0);
    drive(1, 0, 0, 0, 0);
    step();
    check("xwrap", vga_x, 0);
    check("xdone_after_wrap", xdone, 0);
    drive(0, 0, 1, 0, 0);
    step();
    check("ywrap", vga_y, 0);

    // Independent loads on the same edge: x+1, y cleared.
    drive(0, 0, 1, 0, 0);
    repeat (5) step();
    drive(1, 0, 1, 1, 0);
    step();
    check("indep_x", vga_x, 1);
    check("indep_y", vga_y, 0);

    // Combinational plot strobe, pix_count growth, start priority.
    drive(0, 0, 0, 0, 1);
    #1;
    check("vga_plot_comb", vga_plot, 1);
    repeat (500) step();
    check("pix500", pix_count, 500);
    drive(1, 1, 1, 1, 1);
    step();
    check("start_clears_pix", pix_count, 0);
    check("start_x", vga_x, 0);

    // Mid-frame reset from (37,50) with 1000 plots.
    drive(1, 0, 0, 0, 1);
    repeat (37) step();
    drive(0, 0, 1, 0, 1);
    repeat (50) step();
    drive(0, 0, 0, 0, 1);
    repeat (913) step();
    check("mid_x", vga_x, 37);
    check("mid_y", vga_y, 50);
    check("mid_pix", pix_count, 1000);
    reset = 1'b1;
    drive(1, 0, 1, 0, 1);
    step();
    reset = 1'b0;
    check("midrst_x", vga_x, 0);
    check("midrst_y", vga_y, 0);
    check("midrst_pix", pix_count, 0);
    check("midrst_fd", frame_done, 0);

    // Full clear sequence.
    drive(1, 1, 1, 1, 0);
    step();
    nplots = 0;
    done   = 1'b0;
    last_x = 8'd0;
    last_y = 7'd0;
    for (int c = 0; c < 25000 && !done; c++) begin
      last_x = vga_x;
      last_y = vga_y;
      if (xdone) begin
        drive(0, 0, 0, 0, 1);
        done = 1'b1;
      end else if (ydone) begin
        drive(1, 0, 1, 1, 1);
      end else begin
        drive(0, 0, 1, 0, 1);
      end
      step();
      nplots++;
    end
    drive(0, 0, 0, 0, 0);
    check("clear_terminated", done, 1);
    check("clear_nplots", nplots, 19200);
    check("clear_pix", pix_count, 19200);
    check("clear_fd", frame_done, 1);
    check("clear_last_x", last_x, 159);
    check("clear_last_y", last_y, 119);
    repeat (3) step();
    check("fd_sticky", frame_done, 1);
    drive(1, 1, 1, 1, 0);
    step();
    check("fd_start_clear", frame_done, 0);

    // Saturation.
    drive(0, 0, 0, 0, 1);
    repeat (32767) step();
    check("pix_max", pix_count, 32767);
    step();
    check("pix_saturate", pix_count, 32767);
    drive(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clear_datapath.md
CLEAR_DATAPATH -- requirements
Module: clear_datapath

Interface
REQ-001 The module SHALL have parameter XMAX, default 160, meaning screen width in pixels; x range 0..XMAX-1.
REQ-002 The module SHALL have parameter YMAX, default 120, meaning screen height in pixels; y range 0..YMAX-1.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 initx  input  1  when loadx=1: select x <= 0 instead of x+1.
REQ-006 inity  input  1  when loady=1: select y <= 0 instead of y+1.
REQ-007 loadx  input  1  enable x register update this cycle.
REQ-008 loady  input  1  enable y register update this cycle.
REQ-009 plot  input  1  controller request to write current (x,y) this cycle.
REQ-010 xdone  output  1  combinational; 1 iff x==XMAX-1 and y==YMAX-1.
REQ-011 ydone  output  1  combinational; 1 iff y==YMAX-1.
REQ-012 vga_x  output  8  current x register value.
REQ-013 vga_y  output  7  current y register value.
REQ-014 vga_colour  output  3  colour of current pixel.
REQ-015 vga_plot  output  1  combinational copy of plot; write strobe to the VGA adapter.
REQ-016 pix_count  output  15  number of pixels plotted since reset or last x/y init.
REQ-017 frame_done  output  1  sticky; set when a plot occurs with xdone=1.

Function
REQ-018 x SHALL update only when loadx=1: x <= 0 if initx=1, else x+1; otherwise hold.
REQ-019 y SHALL update only when loady=1: y <= 0 if inity=1, else y+1; otherwise hold.
REQ-020 x and y updates SHALL be independent, both taking effect on the same edge when both loads are asserted (e.g. loadx=1, initx=0, loady=1, inity=1 -> x+1, y=0).
REQ-021 Increment of x at XMAX-1 SHALL wrap to 0; increment of y at YMAX-1 SHALL wrap to 0; no other effect.
REQ-022 initx/inity SHALL be ignored when the corresponding load is 0.
REQ-023 vga_colour SHALL equal x[2:0] (vertical colour bars) when CLEAR_BLACK_EN is undefined.
REQ-024 pix_count SHALL increment by 1 on each edge where plot=1, saturating at 2^15-1.
REQ-025 pix_count SHALL clear to 0 on an edge where loadx=1, initx=1, loady=1, inity=1 (controller start), taking priority over an increment in the same cycle.
REQ-026 frame_done SHALL set on an edge where plot=1 and xdone=1, and clear only on reset or on the start condition of REQ-025.
REQ-027 Latency: x, y, pix_count, frame_done SHALL change one cycle after the controlling inputs; xdone, ydone, vga_plot, vga_colour SHALL be combinational from current state and inputs.

Reset
REQ-028 On reset=1 at a rising edge: x=0, y=0, pix_count=0, frame_done=0; hence xdone=0, ydone=0, vga_colour=0.
REQ-029 Reset SHALL take priority over all load and plot inputs, including mid-frame.

Configuration
REQ-030 Macro CLEAR_BLACK_EN: when defined, vga_colour SHALL be constant 3'b000; when undefined, vga_colour follows REQ-023; all other behaviour identical.

Verification
REQ-031 Reset asserted mid-frame (x=37, y=50, pix_count=1000) -> next cycle x=0, y=0, pix_count=0, frame_done=0.
REQ-032 Drive full clear sequence (start cycle, then plot+loady until ydone, then loadx+loady+inity, repeat until xdone) -> exactly 19200 plots, frame_done=1, pix_count=19200, last plotted (x,y)=(159,119).
REQ-033 x=159, y=118 -> xdone=0, ydone=0; advance y to 119 -> ydone=1, xdone=1.
REQ-034 x=159, loadx=1, initx=0 -> x=0; y=119, loady=1, inity=0 -> y=0.
REQ-035 Start condition together with plot=1 and pix_count=500 -> pix_count=0 next cycle.
REQ-036 x=13 without CLEAR_BLACK_EN -> vga_colour=3'b101; with CLEAR_BLACK_EN -> vga_colour=3'b000.
